// File: rtl/divider_seq.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per clock.
// Optional DIVIDER_SIGNED_EN selects two's complement operands (magnitude core + sign fix-up).
module divider_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned REM_W = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [WIDTH-1:0]   dvnd_q, dvnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbz_int_q, dbz_int_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic [REM_W-1:0]   shifted;
    logic [REM_W-1:0]   trial;
    logic [REM_W-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;

`ifdef DIVIDER_SIGNED_EN
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? negate(x) : x;
    endfunction
`endif

    // One restoring iteration; the top remainder bit is always zero between steps.
    always_comb begin
        shifted = REM_W'({rem_q, quo_q[WIDTH-1]});
        trial   = shifted - {1'b0, dvsr_q};
        if (!trial[WIDTH]) begin
            rem_step = trial;
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = shifted;
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        dvnd_d      = dvnd_q;
        cnt_d       = cnt_q;
        dbz_int_d   = dbz_int_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
`ifdef DIVIDER_SIGNED_EN
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    state_d   = RUN;
                    ready_d   = 1'b0;
                    rem_d     = '0;
                    cnt_d     = '0;
                    dvnd_d    = dividend;
                    dbz_int_d = (divisor == '0);
`ifdef DIVIDER_SIGNED_EN
                    quo_d     = magnitude(dividend);
                    dvsr_d    = magnitude(divisor);
                    q_neg_d   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    r_neg_d   = dividend[WIDTH-1];
`else
                    quo_d     = dividend;
                    dvsr_d    = divisor;
`endif
                end
            end
            RUN: begin
                ready_d = 1'b0;
                rem_d   = rem_step;
                quo_d   = quo_step;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    dbz_d   = dbz_int_q;
                    if (dbz_int_q) begin
                        quotient_d  = '1;
                        remainder_d = dvnd_q;
                    end else begin
`ifdef DIVIDER_SIGNED_EN
                        quotient_d  = q_neg_q ? negate(quo_step) : quo_step;
                        remainder_d = r_neg_q ? negate(rem_step[WIDTH-1:0])
                                              : rem_step[WIDTH-1:0];
`else
                        quotient_d  = quo_step;
                        remainder_d = rem_step[WIDTH-1:0];
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            dvnd_q      <= '0;
            cnt_q       <= '0;
            dbz_int_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            dvnd_q      <= dvnd_d;
            cnt_q       <= cnt_d;
            dbz_int_q   <= dbz_int_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
`ifdef DIVIDER_SIGNED_EN
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
`endif
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
